regpair_idu: RTL
================

Name: regpair_idu

Overview:
- Parametrised successor to the single-bit `regbit`: a WIDTH-bit register pair with independent high/low byte-lane loads.
- Adds a built-in increment/decrement unit with a wrap flag, for SM83 register pairs (BC/DE/HL/SP) and address counters.
- LD_MODE selects the load timing:
  - mode 0: conventional level load;
  - mode 1: load commits on the falling edge of `ld`, detected synchronously.
- Provides `q`/`nq` outputs, as the bit-level register cells do.

Parameters:
- WIDTH, 16, total register width; even, >= 4; lane width L = WIDTH/2.
- RESET_VAL, 0, value of `q` after reset.
- LD_MODE, 0, 0 = load at posedge while `ld` high; 1 = load commits on `ld` falling edge.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- nres  in  1  asynchronous active-low reset.
- d_lo  in  L  low-lane load data.
- d_hi  in  L  high-lane load data.
- ld_lo  in  1  low-lane load request.
- ld_hi  in  1  high-lane load request.
- inc  in  1  increment request.
- dec  in  1  decrement request.
- q  out  WIDTH  register value, {hi, lo}.
- nq  out  WIDTH  bitwise complement of `q`.
- zero  out  1  combinational; 1 when q == 0.
- wrap  out  1  registered one-cycle pulse on inc/dec wrap-around.

Behaviour:
- Interface: one clock, `clk`. Reset `nres` is asynchronous and active-low.
- Reset (nres=0), effective immediately and independent of `clk`:
  - q = RESET_VAL, nq = ~RESET_VAL;
  - wrap = 0;
  - mode-1 staging registers and pending flags cleared.
- Reset deasserted mid-pending: the pending load is discarded, not committed.
- Lane commit, per lane x in {lo, hi}:
  - LD_MODE=0: at a posedge with ld_x=1, lane_x <= d_x. Latency 1 edge.
  - LD_MODE=1, staging: at every posedge with ld_x=1, stage_x <= d_x and pend_x <= 1. The last value sampled while ld_x is high wins.
  - LD_MODE=1, commit: at the first posedge with ld_x=0 and pend_x=1, lane_x <= stage_x and pend_x <= 0. This lands one edge later than mode 0.
  - LD_MODE=1: d_x is ignored while ld_x=0.
  - ld_x high for N cycles gives exactly one commit.
- Lanes are independent; both may commit on the same edge.
- Inc/dec:
  - inc=1, dec=0: q <= q + 1 modulo 2^WIDTH, with carry crossing lanes (0x00FF -> 0x0100).
  - dec=1, inc=0: q <= q - 1 modulo 2^WIDTH.
  - inc=1 and dec=1: hold; wrap=0.
- Priority, per cycle:
  - any lane commit on this edge suppresses inc/dec entirely; the non-committing lane holds;
  - in mode 1, a staging-only edge (ld high, no commit) does not block inc/dec.
- Wrap flag:
  - wrap <= 1 on the edge where inc is applied with q = all-ones (result 0);
  - wrap <= 1 on the edge where dec is applied with q = 0 (result all-ones);
  - otherwise wrap <= 0 on every edge.
- No arithmetic flags other than `wrap` and `zero`; there is no half-carry.
- Outputs:
  - nq == ~q at all times, including during reset;
  - `zero` follows q combinationally.

Test Plan:
- Reset: assert nres=0 mid-cycle with q=0x1234 -> q=0x0000, nq=0xFFFF and zero=1 immediately, without a clock edge.
- Mode 0 lane loads: ld_hi=1 with d_hi=0xAA, then ld_lo=1 with d_lo=0x55 on separate edges -> q=0xAA00 then 0xAA55, nq=0x55AA.
- Mode 1 falling-edge load:
  - stimulus: ld_lo held high 3 cycles with d_lo = 0x11, 0x22, 0x33, then dropped;
  - required: q low lane stays 0x00 while ld_lo is high, then becomes 0x33 at the first edge with ld_lo=0 and stays after.
- Reset during pending: mode 1, ld_hi=1 with d_hi=0x7E for 1 cycle, then nres pulse before the commit edge -> q stays RESET_VAL and no later commit occurs.
- Inc/dec wrap:
  - q=0x00FF, inc -> 0x0100, wrap=0;
  - q=0xFFFF, inc -> 0x0000, wrap=1 for exactly one cycle;
  - q=0x0000, dec -> 0xFFFF, wrap=1;
  - inc and dec together -> q unchanged.
- Priority: q=0x10FF, inc=1 with ld_lo=1 and d_lo=0x00 -> q=0x1000 (load wins, no carry into hi); next cycle inc only -> 0x1001.

Source files
------------

// File: rtl/regpair_idu.sv
// regpair_idu: WIDTH-bit register pair with independent byte-lane loads and a
// built-in increment/decrement unit. This is the storage and address-counter
// element behind SM83 register pairs (BC/DE/HL/SP).
//
// Parameters
//   WIDTH     total register width (even, >= 4); lane width L = WIDTH/2
//   RESET_VAL value of q while nres is low
//   LD_MODE   0: lane loads at a posedge while ld_x is high
//             1: ld_x high stages d_x; the load commits at the first posedge
//                after ld_x falls
//
// Ports
//   clk          system clock; all state changes on posedge
//   nres         asynchronous active-low reset
//   d_lo, d_hi   lane load data
//   ld_lo, ld_hi lane load requests
//   inc, dec     increment / decrement requests (both high = hold)
//   q, nq        register value {hi, lo} and its bitwise complement
//   zero         combinational, 1 when q == 0
//   wrap         registered one-cycle pulse when inc/dec wraps around
module regpair_idu #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               LD_MODE   = 0
) (
  input  logic               clk,
  input  logic               nres,
  input  logic [WIDTH/2-1:0] d_lo,
  input  logic [WIDTH/2-1:0] d_hi,
  input  logic               ld_lo,
  input  logic               ld_hi,
  input  logic               inc,
  input  logic               dec,
  output logic [WIDTH-1:0]   q,
  output logic [WIDTH-1:0]   nq,
  output logic               zero,
  output logic               wrap
);

  localparam int L = WIDTH / 2;

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;

  // Per-lane commit strobe and the value that lands when it fires.
  logic         w_cm_lo, w_cm_hi;
  logic [L-1:0] w_new_lo, w_new_hi;

  generate
    if (LD_MODE == 0) begin : g_level
      assign w_cm_lo  = ld_lo;
      assign w_cm_hi  = ld_hi;
      assign w_new_lo = d_lo;
      assign w_new_hi = d_hi;
    end else begin : g_fall
      logic [L-1:0] r_stage_lo, r_stage_hi;
      logic         r_pend_lo, r_pend_hi;

      // Falling edge of ld_x is seen as "pending and ld_x now low"; the last
      // value staged while ld_x was high is the one that commits.
      assign w_cm_lo  = r_pend_lo & ~ld_lo;
      assign w_cm_hi  = r_pend_hi & ~ld_hi;
      assign w_new_lo = r_stage_lo;
      assign w_new_hi = r_stage_hi;

      always_ff @(posedge clk or negedge nres) begin
        if (!nres) begin
          r_stage_lo <= '0;
          r_stage_hi <= '0;
          r_pend_lo  <= 1'b0;
          r_pend_hi  <= 1'b0;
        end else begin
          if (ld_lo) begin
            r_stage_lo <= d_lo;
            r_pend_lo  <= 1'b1;
          end else begin
            r_pend_lo  <= 1'b0;
          end
          if (ld_hi) begin
            r_stage_hi <= d_hi;
            r_pend_hi  <= 1'b1;
          end else begin
            r_pend_hi  <= 1'b0;
          end
        end
      end
    end
  endgenerate

  // Any commit blocks the IDU; in mode 1 a staging-only edge does not.
  logic w_any_cm, w_inc_en, w_dec_en;
  assign w_any_cm = w_cm_lo | w_cm_hi;
  assign w_inc_en = inc & ~dec & ~w_any_cm;
  assign w_dec_en = dec & ~inc & ~w_any_cm;

  logic [WIDTH-1:0] w_q_nxt;
  logic             w_wrap_nxt;

  always_comb begin
    w_q_nxt    = r_q;
    w_wrap_nxt = 1'b0;
    if (w_any_cm) begin
      w_q_nxt = {w_cm_hi ? w_new_hi : r_q[WIDTH-1:L],
                 w_cm_lo ? w_new_lo : r_q[L-1:0]};
    end else if (w_inc_en) begin
      w_q_nxt    = r_q + 1'b1;
      w_wrap_nxt = &r_q;
    end else if (w_dec_en) begin
      w_q_nxt    = r_q - 1'b1;
      w_wrap_nxt = ~|r_q;
    end
  end

  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      r_q    <= RESET_VAL;
      r_wrap <= 1'b0;
    end else begin
      r_q    <= w_q_nxt;
      r_wrap <= w_wrap_nxt;
    end
  end

  assign q    = r_q;
  assign nq   = ~r_q;
  assign zero = (r_q == '0);
  assign wrap = r_wrap;

endmodule
